sram_interface: RTL and testbench

SRAM_INTERFACE -- requirements
Module: sram_interface

---
 rtl/sram_interface.sv | 178 +++++++++++++++++
 tb/tb_sram_interface.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_interface.sv
// Strobe sequencer between the memory controller and a pair of asynchronous SRAM chips.
// One command is executed per handshake; the controller must return CMD_IN to idle to re-arm.
module sram_interface #(
    parameter int WE_CYCLES = 3,
    parameter int RD_CYCLES = 3
) (
    input  logic        CLK_48MHZ,
    input  logic        RESET,
    input  logic [1:0]  CMD_IN,
    input  logic [17:0] ADDRESS_IN,
    input  logic        CHIP_SELECT_IN,
    input  logic [15:0] DATA_IN,
    output logic        SRAM_STATUS,
    output logic [15:0] READ_DATA,
    output logic        READ_VALID,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_CE0_N,
    output logic        SRAM_CE1_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    input  logic [15:0] SRAM_DQ_IN
);

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam int MAX_CYCLES = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_SETUP,
        R_WAIT,
        R_CAPTURE,
        RELEASE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   next_cnt;
    logic               load;
    logic               is_write_cmd;
    logic [17:0]        addr;
    logic               cs;
    logic [15:0]        wdata;
    logic               next_cs;
    logic               next_sel;
    logic               next_ce0_n;
    logic               next_ce1_n;
    logic               next_we_n;
    logic               next_oe_n;
    logic               next_dq_oe;
    logic               next_status;
    logic               ce0_n;
    logic               ce1_n;
    logic               we_n;
    logic               oe_n;
    logic               dq_oe;
    logic               status;
    logic [15:0]        read_data;
    logic               read_valid;

    // Next-state logic; pin levels are decoded from the next state so every SRAM strobe
    // leaves a flop and cannot glitch.
    always_comb begin
        next_state   = state;
        next_cnt     = '0;
        load         = 1'b0;
        is_write_cmd = 1'b0;
        case (state)
            IDLE: begin
                if (CMD_IN == CMD_WRITE) begin
                    next_state   = W_SETUP;
                    load         = 1'b1;
                    is_write_cmd = 1'b1;
                end else if (CMD_IN == CMD_READ) begin
                    next_state = R_SETUP;
                    load       = 1'b1;
                end
            end
            W_SETUP:   next_state = W_PULSE;
            W_PULSE: begin
                if (cnt == WE_LAST) begin
                    next_state = W_HOLD;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            W_HOLD:    next_state = RELEASE;
            R_SETUP:   next_state = R_WAIT;
            R_WAIT: begin
                if (cnt == RD_LAST) begin
                    next_state = R_CAPTURE;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            R_CAPTURE: next_state = RELEASE;
            RELEASE: begin
                if (CMD_IN == CMD_IDLE) begin
                    next_state = IDLE;
                end
            end
            default:   next_state = IDLE;
        endcase

        next_cs     = load ? CHIP_SELECT_IN : cs;
        next_sel    = (next_state != IDLE) && (next_state != RELEASE);
        next_ce0_n  = !(next_sel && !next_cs);
        next_ce1_n  = !(next_sel && next_cs);
        next_we_n   = (next_state != W_PULSE);
        next_oe_n   = !((next_state == R_WAIT) || (next_state == R_CAPTURE));
        next_dq_oe  = (next_state == W_SETUP) || (next_state == W_PULSE) ||
                      (next_state == W_HOLD);
        next_status = (next_state != IDLE);
    end

    always_ff @(posedge CLK_48MHZ) begin
        if (!RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            addr       <= '0;
            cs         <= 1'b0;
            wdata      <= '0;
            ce0_n      <= 1'b1;
            ce1_n      <= 1'b1;
            we_n       <= 1'b1;
            oe_n       <= 1'b1;
            dq_oe      <= 1'b0;
            status     <= 1'b0;
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            ce0_n  <= next_ce0_n;
            ce1_n  <= next_ce1_n;
            we_n   <= next_we_n;
            oe_n   <= next_oe_n;
            dq_oe  <= next_dq_oe;
            status <= next_status;
            if (load) begin
                addr <= ADDRESS_IN;
                cs   <= CHIP_SELECT_IN;
            end
            if (is_write_cmd) begin
                wdata <= DATA_IN;
            end
            // Sample the bus at the end of the last OE-low cycle; the valid pulse lines up
            // with the new READ_DATA value.
            read_valid <= (state == R_CAPTURE);
            if (state == R_CAPTURE) begin
                read_data <= SRAM_DQ_IN;
            end
        end
    end

    assign SRAM_STATUS = status;
    assign READ_DATA   = read_data;
    assign READ_VALID  = read_valid;
    assign SRAM_ADDR   = addr;
    assign SRAM_CE0_N  = ce0_n;
    assign SRAM_CE1_N  = ce1_n;
    assign SRAM_WE_N   = we_n;
    assign SRAM_OE_N   = oe_n;
    assign SRAM_DQ_OUT = wdata;
    assign SRAM_DQ_OE  = dq_oe;

endmodule

// File: tb/tb_sram_interface.sv
// Randomised bench for sram_interface: a behavioural SRAM on the pins, a reference memory
// and per-operation timing rules (busy length, strobe counts) derived from command semantics.
module tb_sram_interface;

    localparam int WE = 3;
    localparam int RD = 3;

    logic        clk;
    logic        rst_n;
    logic [1:0]  cmd;
    logic [17:0] address;
    logic        chip_select;
    logic [15:0] data;
    logic        sram_status;
    logic [15:0] read_data;
    logic        read_valid;
    logic [17:0] sram_addr;
    logic        ce0_n;
    logic        ce1_n;
    logic        we_n;
    logic        oe_n;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [15:0] dq_in;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] sram_mem [int];
    logic [15:0] ref_mem [int];
    logic [15:0] last_read = 16'h0000;

    sram_interface #(.WE_CYCLES(WE), .RD_CYCLES(RD)) dut (
        .CLK_48MHZ      (clk),
        .RESET          (rst_n),
        .CMD_IN         (cmd),
        .ADDRESS_IN     (address),
        .CHIP_SELECT_IN (chip_select),
        .DATA_IN        (data),
        .SRAM_STATUS    (sram_status),
        .READ_DATA      (read_data),
        .READ_VALID     (read_valid),
        .SRAM_ADDR      (sram_addr),
        .SRAM_CE0_N     (ce0_n),
        .SRAM_CE1_N     (ce1_n),
        .SRAM_WE_N      (we_n),
        .SRAM_OE_N      (oe_n),
        .SRAM_DQ_OUT    (dq_out),
        .SRAM_DQ_OE     (dq_oe),
        .SRAM_DQ_IN     (dq_in)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural SRAM: stores while WE is low, returns stored word while OE is low,
    // otherwise the bus floats to random garbage.
    always @(negedge clk) begin
        int key;
        key = int'({13'b0, (ce1_n == 1'b0), sram_addr});
        if (!we_n && (ce0_n != ce1_n)) begin
            sram_mem[key] = dq_out;
        end
        if (!oe_n && (ce0_n != ce1_n)) begin
            dq_in = sram_mem.exists(key) ? sram_mem[key] : 16'hDEAD;
        end else begin
            dq_in = 16'($urandom);
        end
    end

    task automatic run_op(input bit is_write, input logic [17:0] a, input logic c,
                          input logic [15:0] d, input int hold, input bit scramble,
                          input string name);
        int busy, we_low, we_pulses, oe_low, valid_cnt, valid_at, base, key;
        bit prev_we_n, done;
        logic [15:0] exp_rd;
        key = int'({13'b0, c, a});
        exp_rd = ref_mem.exists(key) ? ref_mem[key] : 16'hDEAD;
        base = (is_write ? WE : RD) + 3;
        busy = 0; we_low = 0; we_pulses = 0; oe_low = 0; valid_cnt = 0; valid_at = 0;
        prev_we_n = 1'b1;
        done = 1'b0;
        cmd = is_write ? 2'b10 : 2'b01;
        address = a;
        chip_select = c;
        data = d;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (sram_status) begin
                busy++;
                if (!we_n) we_low++;
                if (!we_n && prev_we_n) we_pulses++;
                if (!oe_n) oe_low++;
                vectors++;
                if (sram_addr !== a) begin
                    miscompares++;
                    $display("[TB] FAIL %s addr: got %h expected %h", name, sram_addr, a);
                end
                vectors++;
                if ((c ? ce0_n : ce1_n) !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL %s unselected_ce: got 0 expected 1", name);
                end
                if (!we_n || !oe_n || dq_oe) begin
                    vectors++;
                    if ((c ? ce1_n : ce0_n) !== 1'b0) begin
                        miscompares++;
                        $display("[TB] FAIL %s selected_ce: got 1 expected 0", name);
                    end
                end
                vectors++;
                if (dq_oe && !oe_n) begin
                    miscompares++;
                    $display("[TB] FAIL %s contention: got dq_oe=1 oe_n=0 expected never", name);
                end
                if (dq_oe) begin
                    vectors++;
                    if (dq_out !== d) begin
                        miscompares++;
                        $display("[TB] FAIL %s dq_out: got %h expected %h", name, dq_out, d);
                    end
                end
                if (!is_write) begin
                    vectors++;
                    if (dq_oe !== 1'b0) begin
                        miscompares++;
                        $display("[TB] FAIL %s read_dq_oe: got 1 expected 0", name);
                    end
                end
            end else begin
                if (busy == 0) begin
                    miscompares++;
                    $display("[TB] FAIL %s no_busy: got status 0 expected 1", name);
                end
                done = 1'b1;
                vectors++;
                if (we_n !== 1'b1 || oe_n !== 1'b1 || ce0_n !== 1'b1 || ce1_n !== 1'b1 ||
                    dq_oe !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL %s idle_pins: got we%b oe%b ce%b%b dqoe%b expected 1 1 11 0",
                             name, we_n, oe_n, ce0_n, ce1_n, dq_oe);
                end
            end
            if (read_valid) begin
                valid_cnt++;
                valid_at = busy;
                vectors++;
                if (read_data !== exp_rd) begin
                    miscompares++;
                    $display("[TB] FAIL %s read_data: got %h expected %h", name, read_data, exp_rd);
                end
            end
            prev_we_n = we_n;
            if (!done && cmd != 2'b00 && busy >= hold) cmd = 2'b00;
            if (scramble && busy > 0) begin
                address = 18'($urandom);
                data = 16'($urandom);
            end
        end
        cmd = 2'b00;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("[TB] FAIL %s timeout: got busy %0d expected completion", name, busy);
        end
        vectors++;
        if (busy != ((hold > base) ? hold : base)) begin
            miscompares++;
            $display("[TB] FAIL %s busy_len: got %0d expected %0d", name, busy,
                     (hold > base) ? hold : base);
        end
        vectors++;
        if (we_low != (is_write ? WE : 0) || we_pulses != (is_write ? 1 : 0)) begin
            miscompares++;
            $display("[TB] FAIL %s we_strobe: got low %0d pulses %0d expected low %0d pulses %0d",
                     name, we_low, we_pulses, is_write ? WE : 0, is_write ? 1 : 0);
        end
        vectors++;
        if (oe_low != (is_write ? 0 : RD + 1)) begin
            miscompares++;
            $display("[TB] FAIL %s oe_strobe: got %0d expected %0d", name, oe_low,
                     is_write ? 0 : RD + 1);
        end
        vectors++;
        if (valid_cnt != (is_write ? 0 : 1) || (!is_write && valid_at != RD + 3)) begin
            miscompares++;
            $display("[TB] FAIL %s read_valid: got count %0d at %0d expected count %0d at %0d",
                     name, valid_cnt, valid_at, is_write ? 0 : 1, RD + 3);
        end
        if (is_write) ref_mem[key] = d;
        else last_read = exp_rd;
        vectors++;
        if (read_data !== last_read) begin
            miscompares++;
            $display("[TB] FAIL %s read_data_hold: got %h expected %h", name, read_data, last_read);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd = 2'b10;
        address = 18'h2AAAA;
        chip_select = 1'b1;
        data = 16'hFFFF;
        repeat (3) @(negedge clk);
        vectors++;
        if (sram_status !== 1'b0 || read_valid !== 1'b0 || read_data !== 16'h0 ||
            sram_addr !== 18'h0 || ce0_n !== 1'b1 || ce1_n !== 1'b1 || we_n !== 1'b1 ||
            oe_n !== 1'b1 || dq_oe !== 1'b0 || dq_out !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got st%b rv%b rd%h a%h ce%b%b we%b oe%b dqoe%b dq%h expected all idle/zero",
                     sram_status, read_valid, read_data, sram_addr, ce0_n, ce1_n, we_n, oe_n,
                     dq_oe, dq_out);
        end
        cmd = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reserved();
        cmd = 2'b11;
        address = 18'h12345;
        data = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (sram_status !== 1'b0 || we_n !== 1'b1 || oe_n !== 1'b1 ||
                ce0_n !== 1'b1 || ce1_n !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL reserved_cmd: got st%b we%b oe%b ce%b%b expected 0 1 1 11",
                         sram_status, we_n, oe_n, ce0_n, ce1_n);
            end
        end
        cmd = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_op(1'b1, 18'h000A5, 1'b1, 16'hBEEF, 1, 1'b0, "write_basic");
        run_op(1'b1, 18'h3FFFF, 1'b0, 16'h1234, 1, 1'b0, "write_preload");
        run_op(1'b0, 18'h3FFFF, 1'b0, 16'h0000, 1, 1'b0, "read_basic");
        vectors++;
        if (read_data !== 16'h1234) begin
            miscompares++;
            $display("[TB] FAIL read_basic_value: got %h expected 1234", read_data);
        end
        run_op(1'b0, 18'h000A5, 1'b1, 16'h0000, 1, 1'b0, "read_beef");
    endtask

    task automatic test_held_command();
        run_op(1'b1, 18'h01234, 1'b0, 16'hC0DE, 12, 1'b0, "held_write");
        run_op(1'b0, 18'h01234, 1'b0, 16'h0000, 12, 1'b0, "held_read");
    endtask

    task automatic test_input_change();
        run_op(1'b1, 18'h2468A, 1'b1, 16'h7E57, 2, 1'b1, "scrambled_write");
        run_op(1'b0, 18'h2468A, 1'b1, 16'h0000, 2, 1'b1, "scrambled_read");
    endtask

    task automatic test_reset_mid_op();
        cmd = 2'b10;
        address = 18'h01555;
        chip_select = 1'b0;
        data = 16'hA5A5;
        repeat (2) @(negedge clk);
        vectors++;
        if (we_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midop_pulse: got we_n %b expected 0", we_n);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (we_n !== 1'b1 || sram_status !== 1'b0 || sram_addr !== 18'h0 ||
            ce0_n !== 1'b1 || ce1_n !== 1'b1 || oe_n !== 1'b1 || dq_oe !== 1'b0 ||
            dq_out !== 16'h0 || read_data !== 16'h0 || read_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midop_reset: got we%b st%b a%h ce%b%b oe%b dqoe%b dq%h rd%h rv%b expected reset values",
                     we_n, sram_status, sram_addr, ce0_n, ce1_n, oe_n, dq_oe, dq_out,
                     read_data, read_valid);
        end
        last_read = 16'h0000;
        cmd = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b1, 18'h00777, 1'b1, 16'h9ABC, 1, 1'b0, "after_reset_write");
        run_op(1'b0, 18'h00777, 1'b1, 16'h0000, 1, 1'b0, "after_reset_read");

        cmd = 2'b01;
        address = 18'h00777;
        chip_select = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        cmd = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        last_read = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (read_valid !== 1'b0 || sram_status !== 1'b0 || read_data !== 16'h0) begin
                miscompares++;
                $display("[TB] FAIL aborted_read: got rv%b st%b rd%h expected 0 0 0000",
                         read_valid, sram_status, read_data);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            logic [17:0] a;
            logic c;
            logic [15:0] d;
            a = 18'($urandom);
            c = 1'($urandom);
            d = 16'($urandom);
            run_op(1'b1, a, c, d, $urandom_range(1, 9), 1'($urandom), "random_write");
            run_op(1'b0, a, c, 16'h0000, $urandom_range(1, 9), 1'($urandom), "random_read");
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] qa[$];
        logic        qc[$];
        for (int i = 0; i < 6; i++) begin
            qa.push_back(18'($urandom));
            qc.push_back(1'($urandom));
            run_op(1'b1, qa[i], qc[i], 16'($urandom), 1, 1'b0, "b2b_write");
        end
        for (int i = 5; i >= 0; i--) begin
            run_op(1'b0, qa[i], qc[i], 16'h0000, 1, 1'b0, "b2b_read");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd = 2'b00;
        address = '0;
        chip_select = 1'b0;
        data = '0;
        dq_in = '0;
        test_reset();
        test_reserved();
        test_basic();
        test_held_command();
        test_input_change();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
